// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time: latches operands, runs the divider for exactly
// DIV_LATENCY enabled cycles, traps zero divisors and returns the result over valid/ready.
module alu_sequencer #(
   parameter int WIDTH       = 16,
   parameter int DIV_LATENCY = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_divzero,
   output logic             busy,
   output logic [WIDTH-1:0] alu_dataa,
   output logic [WIDTH-1:0] alu_datab,
   output logic [1:0]       alu_s,
   output logic             alu_diven,
   input  logic [WIDTH-1:0] alu_result
);

   typedef enum logic [1:0] {IDLE, DIVWAIT, EXEC, RESP} state_t;

   localparam logic [1:0] OP_DIV   = 2'b11;
   localparam logic [3:0] CNT_INIT = 4'(DIV_LATENCY - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             divzero_q, divzero_d;
   logic [WIDTH-1:0] dataa_q, dataa_d;
   logic [WIDTH-1:0] datab_q, datab_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_divzero_q, rsp_divzero_d;
   logic             accept;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      divzero_d     = divzero_q;
      dataa_d       = dataa_q;
      datab_d       = datab_q;
      sel_d         = sel_q;
      rsp_data_d    = rsp_data_q;
      rsp_divzero_d = rsp_divzero_q;
      accept        = req_valid && (state_q == IDLE);

      case (state_q)
         IDLE: begin
            if (accept) begin
               dataa_d   = req_a;
               datab_d   = req_b;
               sel_d     = req_op;
               divzero_d = (req_op == OP_DIV) && (req_a == '0);
               // A zero divisor skips the divider entirely so it never sees a zero denominator.
               if ((req_op == OP_DIV) && (req_a != '0)) begin
                  state_d = DIVWAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = EXEC;
               end
            end
         end
         DIVWAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = EXEC;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         EXEC: begin
            rsp_data_d    = divzero_q ? '1 : alu_result;
            rsp_divzero_d = divzero_q;
            state_d       = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         divzero_q     <= 1'b0;
         dataa_q       <= '0;
         datab_q       <= '0;
         sel_q         <= 2'b00;
         rsp_data_q    <= '0;
         rsp_divzero_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         divzero_q     <= divzero_d;
         dataa_q       <= dataa_d;
         datab_q       <= datab_d;
         sel_q         <= sel_d;
         rsp_data_q    <= rsp_data_d;
         rsp_divzero_q <= rsp_divzero_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign rsp_valid   = (state_q == RESP);
   assign alu_diven   = (state_q == DIVWAIT);
   assign rsp_data    = rsp_data_q;
   assign rsp_divzero = rsp_divzero_q;
   assign alu_dataa   = dataa_q;
   assign alu_datab   = datab_q;
   assign alu_s       = sel_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU with a clock-enabled divider pipeline, directed
// cases followed by random operations checked against an arithmetic reference model.
module tb_alu_sequencer;
   localparam int W  = 16;
   localparam int DL = 4;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          req_valid, req_ready;
   logic [1:0]    req_op;
   logic [W-1:0]  req_a, req_b;
   logic          rsp_valid, rsp_ready;
   logic [W-1:0]  rsp_data;
   logic          rsp_divzero, busy;
   logic [W-1:0]  alu_dataa, alu_datab;
   logic [1:0]    alu_s;
   logic          alu_diven;
   logic [W-1:0]  alu_result;

   int vectors     = 0;
   int miscompares = 0;

   alu_sequencer #(.WIDTH(W), .DIV_LATENCY(DL)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_divzero(rsp_divzero), .busy(busy),
      .alu_dataa(alu_dataa), .alu_datab(alu_datab), .alu_s(alu_s),
      .alu_diven(alu_diven), .alu_result(alu_result)
   );

   always #5 clock = ~clock;

   // ALU: add/sub/mul are combinational, the quotient emerges after DL enabled edges.
   logic [W-1:0] div_pipe [DL];
   logic [W-1:0] quotient;
   logic [31:0]  product;

   always_comb begin
      quotient = (alu_dataa == '0) ? 16'h0BAD : W'($signed(alu_datab) / $signed(alu_dataa));
      product  = 32'($signed(alu_dataa) * $signed(alu_datab));
      case (alu_s)
         2'b00:   alu_result = alu_dataa + alu_datab;
         2'b01:   alu_result = alu_dataa - alu_datab;
         2'b10:   alu_result = product[W-1:0];
         default: alu_result = div_pipe[DL-1];
      endcase
   end

   always @(posedge clock) begin
      if (alu_diven) begin
         for (int i = DL - 1; i > 0; i--) div_pipe[i] <= div_pipe[i-1];
         div_pipe[0] <= quotient;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
         2'b00:   return W'(sa + sb);
         2'b01:   return W'(sa - sb);
         2'b10:   return W'(sa * sb);
         default: return (a == '0) ? {W{1'b1}} : W'(sb / sa);
      endcase
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue one request, follow it to its response, hold off rsp_ready for 'hold' cycles.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold);
      logic [W-1:0] exp_data;
      logic         exp_dz;
      int           exp_lat, exp_en, lat, en;
      exp_data = ref_result(op, a, b);
      exp_dz   = (op == 2'b11) && (a == '0);
      exp_lat  = (op == 2'b11 && a != '0) ? 2 + DL : 2;
      exp_en   = (op == 2'b11 && a != '0) ? DL : 0;

      check("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      rsp_ready = (hold == 0);
      tick();
      req_valid = 1'b0; req_a = W'($urandom); req_b = W'($urandom); req_op = 2'($urandom);
      lat = 1; en = 0;
      while (!rsp_valid && lat < 60) begin
         check("busy_wait", {30'd0, busy, req_ready}, 32'd2);
         if (alu_diven) en++;
         tick();
         lat++;
      end
      check("latency", lat, exp_lat);
      check("diven_cycles", en, exp_en);
      check("rsp_data", {16'd0, rsp_data}, {16'd0, exp_data});
      check("rsp_divzero", {31'd0, rsp_divzero}, {31'd0, exp_dz});
      check("operands", {alu_s, alu_dataa, alu_datab[13:0]}, {op, a, b[13:0]});

      for (int i = 0; i < hold; i++) begin
         req_valid = (i == 0);
         req_op = 2'b00; req_a = 16'h1111; req_b = 16'h2222;
         tick();
         check("hold_data", {15'd0, rsp_divzero, rsp_data}, {15'd0, exp_dz, exp_data});
         check("hold_flags", {29'd0, rsp_valid, busy, req_ready}, 32'd6);
         check("hold_operands", {16'd0, alu_dataa}, {16'd0, a});
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      if (hold > 0) tick();
      else if (rsp_valid) tick();
      check("back_to_idle", {30'd0, rsp_valid, req_ready}, 32'd1);
   endtask

   initial begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      reset_n = 1'b0; req_valid = 1'b0; req_op = 2'b00;
      req_a = '0; req_b = '0; rsp_ready = 1'b0;
      tick();
      tick();
      check("rst_flags", {27'd0, req_ready, busy, rsp_valid, rsp_divzero, alu_diven}, 32'h10);
      check("rst_data", {16'd0, rsp_data}, 32'd0);
      check("rst_alu", {alu_s, alu_dataa, alu_datab[13:0]}, 32'd0);
      reset_n = 1'b1;

      run_op(2'b00, 16'd5, 16'd3, 0);
      check("add_const", {16'd0, rsp_data}, 32'h0008);
      run_op(2'b01, 16'd3, 16'd5, 0);
      check("sub_const", {16'd0, rsp_data}, 32'hFFFE);
      run_op(2'b10, 16'd300, 16'd300, 0);
      check("mul_const", {16'd0, rsp_data}, 32'h5F90);
      run_op(2'b11, 16'd7, 16'd100, 0);
      check("div_const", {16'd0, rsp_data}, 32'h000E);
      run_op(2'b11, 16'd0, 16'd1234, 0);
      check("divzero_const", {15'd0, rsp_divzero, rsp_data}, 32'h1FFFF);
      run_op(2'b00, 16'd1, 16'd1, 5);

      // Reset during the second divider cycle, then a full-latency divide.
      req_valid = 1'b1; req_op = 2'b11; req_a = 16'd9; req_b = 16'd900;
      tick();
      req_valid = 1'b0;
      tick();
      check("mid_div_en", {31'd0, alu_diven}, 32'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("mrst_flags", {27'd0, req_ready, busy, rsp_valid, rsp_divzero, alu_diven}, 32'h10);
      check("mrst_data", {16'd0, rsp_data}, 32'd0);
      check("mrst_alu", {alu_s, alu_dataa, alu_datab[13:0]}, 32'd0);
      run_op(2'b11, 16'd7, 16'd100, 0);

      for (int n = 0; n < 40; n++) begin
         op = 2'($urandom);
         a  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
         b  = W'($urandom);
         if (op == 2'b11 && a == 16'hFFFF && b == 16'h8000) b = 16'h7FFF;
         run_op(op, a, b, int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
